// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if -- bus bundle for the 4-channel TDM demultiplexer.
//
// Groups the serial input side (din, din_valid, sync), the word output side
// (q0..q3, out_valid, out_ready) and the status flags (locked, sync_err,
// overrun). clk/rst stay plain module ports.
//
// Modports:
//   slave  : the demultiplexer (consumes serial beats, drives words/status)
//   master : the environment (drives serial beats and out_ready)
//
// Parameter:
//   W : bits per channel word (= frames per word), 2..32
interface tdm_demux4_if #(
  parameter int unsigned W = 8
);
  logic         din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] q0;
  logic [W-1:0] q1;
  logic [W-1:0] q2;
  logic [W-1:0] q3;
  logic         out_valid;
  logic         out_ready;
  logic         locked;
  logic         sync_err;
  logic         overrun;

  modport slave (
    input  din, din_valid, sync, out_ready,
    output q0, q1, q2, q3, out_valid, locked, sync_err, overrun
  );

  modport master (
    output din, din_valid, sync, out_ready,
    input  q0, q1, q2, q3, out_valid, locked, sync_err, overrun
  );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4 -- four-channel time-division demultiplexer.
//
// Recovers slot alignment from a frame sync marker on the slot-0 beat,
// routes each slot's bit into that channel's shift register (first bit
// received ends up as the MSB) and, after W frames, presents the four
// W-bit words on a valid/ready output.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : tdm_demux4_if.slave
//         din/din_valid/sync in, out_ready in,
//         q0..q3/out_valid out, locked/sync_err/overrun status out
//
// Parameter:
//   W : bits per channel word, also frames per word (2..32)
//
// Build option:
//   TDM_DEMUX_SYNC_CHECK_EN : when defined, sync is checked on every valid
//   beat in LOCKED; misplaced sync realigns, missing sync drops to HUNT.
//   When undefined, sync is ignored once locked and sync_err is always 0.
module tdm_demux4 #(
  parameter int unsigned W = 8
) (
  input  logic            clk,
  input  logic            rst,
  tdm_demux4_if.slave     bus
);

  localparam int unsigned FCW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t         state_q,  state_d;
  logic [1:0]     slot_q,   slot_d;
  logic [FCW-1:0] fcnt_q,   fcnt_d;
  logic [W-1:0]   sh_q [4];
  logic [W-1:0]   sh_d [4];
  logic [W-1:0]   word_q [4];
  logic [W-1:0]   word_d [4];
  logic           valid_q,  valid_d;
  logic           err_q,    err_d;
  logic           ovr_q,    ovr_d;
  logic           complete;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    fcnt_d   = fcnt_q;
    sh_d     = sh_q;
    word_d   = word_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    ovr_d    = 1'b0;
    complete = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          // The sync beat itself carries the slot-0 bit of frame 0.
          if (bus.sync) begin
            state_d  = LOCKED;
            slot_d   = 2'd1;
            fcnt_d   = '0;
            sh_d[0]  = {sh_q[0][W-2:0], bus.din};
          end
        end
        LOCKED: begin
          sh_d[slot_q] = {sh_q[slot_q][W-2:0], bus.din};
          slot_d       = slot_q + 2'd1;
          if (slot_q == 2'd3) begin
            if (fcnt_q == FCW'(W - 1)) begin
              fcnt_d   = '0;
              complete = 1'b1;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
`ifdef TDM_DEMUX_SYNC_CHECK_EN
          // Framing errors override the normal shift/advance above.
          if (bus.sync && (slot_q != 2'd0)) begin
            err_d    = 1'b1;
            complete = 1'b0;
            sh_d     = '{default: '0};
            sh_d[0]  = {{(W-1){1'b0}}, bus.din};
            slot_d   = 2'd1;
            fcnt_d   = '0;
          end else if (!bus.sync && (slot_q == 2'd0)) begin
            err_d    = 1'b1;
            complete = 1'b0;
            sh_d     = '{default: '0};
            state_d  = HUNT;
            slot_d   = 2'd0;
            fcnt_d   = '0;
          end
`endif
        end
        default: ;
      endcase
    end

    // A completion takes priority over a plain transfer: if the held set
    // leaves on this edge the new set replaces it and valid stays high.
    if (complete) begin
      if (!valid_q || bus.out_ready) begin
        word_d[0] = sh_d[0];
        word_d[1] = sh_d[1];
        word_d[2] = sh_d[2];
        word_d[3] = sh_d[3];
        valid_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
      fcnt_q  <= '0;
      sh_q    <= '{default: '0};
      word_q  <= '{default: '0};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      fcnt_q  <= fcnt_d;
      sh_q    <= sh_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.q0        = word_q[0];
  assign bus.q1        = word_q[1];
  assign bus.q2        = word_q[2];
  assign bus.q3        = word_q[3];
  assign bus.out_valid = valid_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.sync_err  = err_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 -- self-checking bench for tdm_demux4 (W = 8).
//
// Every cycle the DUT outputs are compared with a frame/slot-indexed
// reference model; directed sequences and a vector table add explicit
// checks against constant expectations.
module tb_tdm_demux4;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4 * W + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_demux4_if #(.W(W)) bus ();

  tdm_demux4 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk   = 0;
  int n_pass  = 0;
  int ovr_cnt = 0;
  int err_cnt = 0;

  // Reference model: bits stored by [channel][frame], words assembled on demand.
  bit           m_locked;
  int           m_slot;
  int           m_frame;
  bit           m_bits [4][32];
  logic [W-1:0] m_q [4];
  bit           m_ov;
  bit           m_err;
  bit           m_ovr;

  typedef struct {
    logic [4*W-1:0] win;
    int             gap;
    logic [4*W-1:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] pack(input int c);
    logic [W-1:0] w;
    for (int unsigned i = 0; i < W; i++) w[W-1-i] = m_bits[c][i];
    return w;
  endfunction

  task automatic model_step();
    bit xfer, complete, handled;
    xfer     = m_ov && bus.out_ready;
    complete = 0;
    handled  = 0;
    m_err    = 0;
    m_ovr    = 0;
    if (rst) begin
      m_locked = 0; m_slot = 0; m_frame = 0; m_ov = 0;
      for (int c = 0; c < 4; c++) m_q[c] = '0;
      return;
    end
    if (bus.din_valid) begin
      if (!m_locked) begin
        if (bus.sync) begin
          m_locked = 1; m_bits[0][0] = bus.din; m_slot = 1; m_frame = 0;
        end
      end else begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        if (bus.sync && m_slot != 0) begin
          m_err = 1; m_bits[0][0] = bus.din; m_slot = 1; m_frame = 0; handled = 1;
        end else if (!bus.sync && m_slot == 0) begin
          m_err = 1; m_locked = 0; m_slot = 0; m_frame = 0; handled = 1;
        end
`endif
        if (!handled) begin
          m_bits[m_slot][m_frame] = bus.din;
          complete = (m_slot == 3) && (m_frame == int'(W) - 1);
          m_slot++;
          if (m_slot == 4) begin
            m_slot  = 0;
            m_frame = (m_frame + 1) % int'(W);
          end
        end
      end
    end
    if (complete) begin
      if (!m_ov || bus.out_ready) begin
        for (int c = 0; c < 4; c++) m_q[c] = pack(c);
        m_ov = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (xfer) begin
      m_ov = 0;
    end
  endtask

  task automatic cycle(input logic d, input logic v, input logic s, input logic r);
    bus.din       = d;
    bus.din_valid = v;
    bus.sync      = s;
    bus.out_ready = r;
    @(posedge clk);
    model_step();
    #1;
    check("cycle", {bus.q0, bus.q1, bus.q2, bus.q3, bus.out_valid, bus.locked, bus.sync_err, bus.overrun},
                   {m_q[0], m_q[1], m_q[2], m_q[3], m_ov, m_locked, m_err, m_ovr});
    if (bus.overrun)  ovr_cnt++;
    if (bus.sync_err) err_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // One full word set, sync on every slot-0 beat; rdy_last applies to the final beat only.
  task automatic send_set(input logic [4*W-1:0] win, input int gap, input logic rdy, input logic rdy_last);
    logic [W-1:0] w [4];
    bit           last;
    w[0] = win[4*W-1 -: W];
    w[1] = win[3*W-1 -: W];
    w[2] = win[2*W-1 -: W];
    w[3] = win[W-1 -: W];
    for (int unsigned f = 0; f < W; f++) begin
      for (int c = 0; c < 4; c++) begin
        last = (f == W - 1) && (c == 3);
        cycle(w[c][W-1-f], 1'b1, c == 0, last ? rdy_last : rdy);
        if (!last)
          for (int g = 0; g < gap; g++) cycle(1'($urandom), 1'b0, 1'($urandom), rdy);
      end
    end
  endtask

  initial begin
    vecs[0] = '{win: {8'hAA, 8'hFF, 8'h00, 8'h0F}, gap: 0, exp: {8'hAA, 8'hFF, 8'h00, 8'h0F}};
    vecs[1] = '{win: {8'h55, 8'h00, 8'hFF, 8'hF0}, gap: 0, exp: {8'h55, 8'h00, 8'hFF, 8'hF0}};
    vecs[2] = '{win: {8'h3C, 8'h81, 8'h7E, 8'hC3}, gap: 1, exp: {8'h3C, 8'h81, 8'h7E, 8'hC3}};
    vecs[3] = '{win: {8'hAA, 8'hFF, 8'h00, 8'h0F}, gap: 3, exp: {8'hAA, 8'hFF, 8'h00, 8'h0F}};

    bus.din = 1'b0; bus.din_valid = 1'b0; bus.sync = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    do_reset();
    check("reset_outputs", {bus.q0, bus.q1, bus.q2, bus.q3, bus.out_valid, bus.locked, bus.sync_err, bus.overrun}, '0);

    // Hunt: valid beats without sync are ignored
    for (int i = 0; i < 5; i++) cycle(1'($urandom), 1'b1, 1'b0, 1'b1);
    check("hunt_unlocked", bus.locked, 1'b0);

    // Framing table, including the first lock from HUNT and the gap case
    for (int i = 0; i < 4; i++) begin
      send_set(vecs[i].win, vecs[i].gap, 1'b1, 1'b1);
      check("table_valid", bus.out_valid, 1'b1);
      check("table_words", {bus.q0, bus.q1, bus.q2, bus.q3}, vecs[i].exp);
      check("table_locked", bus.locked, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check("table_drained", bus.out_valid, 1'b0);
    end

    // Reset mid-word
    for (int i = 0; i < 10; i++) cycle(1'($urandom), 1'b1, (i % 4) == 0, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    check("midreset_outputs", {bus.q0, bus.q1, bus.q2, bus.q3, bus.out_valid, bus.locked, bus.sync_err, bus.overrun}, '0);

    // Backpressure: second set dropped
    ovr_cnt = 0;
    send_set({8'hAA, 8'hFF, 8'h00, 8'h0F}, 0, 1'b0, 1'b0);
    check("bp_first_valid", bus.out_valid, 1'b1);
    send_set({8'h55, 8'h11, 8'h22, 8'h33}, 0, 1'b0, 1'b0);
    check("bp_overrun_count", ovr_cnt, 1);
    check("bp_q0_held", bus.q0, 8'hAA);
    check("bp_valid_held", bus.out_valid, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_after_transfer", bus.out_valid, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_single_transfer", bus.out_valid, 1'b0);

    // Transfer and completion on the same edge
    send_set({8'hAA, 8'hFF, 8'h00, 8'h0F}, 0, 1'b0, 1'b0);
    ovr_cnt = 0;
    send_set({8'h3C, 8'h81, 8'h7E, 8'hC3}, 0, 1'b0, 1'b1);
    check("simul_words", {bus.q0, bus.q1, bus.q2, bus.q3}, {8'h3C, 8'h81, 8'h7E, 8'hC3});
    check("simul_valid", bus.out_valid, 1'b1);
    check("simul_no_overrun", ovr_cnt, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Sync marker at slot 2
    err_cnt = 0;
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    send_set({8'h81, 8'h42, 8'h24, 8'h18}, 0, 1'b1, 1'b1);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    check("misplaced_sync_err", err_cnt, 1);
    check("realigned_words", {bus.q0, bus.q1, bus.q2, bus.q3}, {8'h81, 8'h42, 8'h24, 8'h18});
`else
    check("misplaced_sync_noerr", err_cnt, 0);
`endif
    check("misplaced_locked", bus.locked, 1'b1);

    // Missing sync at slot 0
    err_cnt = 0;
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    check("missing_sync_err", err_cnt, 1);
    check("missing_sync_unlocked", bus.locked, 1'b0);
`else
    check("missing_sync_noerr", err_cnt, 0);
    check("missing_sync_locked", bus.locked, 1'b1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic v, s, r;
      v = ($urandom_range(0, 9) < 7);
      s = m_locked ? (m_slot == 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) s = !s;
      r = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 999) == 0);
      cycle(1'($urandom), v, s, r);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
